fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the pipelined RV32I core: holds the program counter, drives the word-addressed instruction memory, and registers the fetched word into the IF/ID pipeline register consumed by decode. Handles sequential PC+4 advance, branch/jump redirect from execute, load-use stall and control-hazard flush from the hazard unit.

---
 rtl/fetch_stage.sv | 67 ++++++
 tb/tb_fetch_stage.sv | 113 +++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with PC, word-indexed imem drive and IF/ID register.
// Ports: clk, rst (sync, active-high); stall_f/stall_d/flush_d from hazard unit;
// pc_src_e/pc_target_e redirect from execute; imem_addr/imem_rd to instruction memory;
// pc_f fetch PC; instr_d/pc_d/pc_plus4_d/valid_d IF/ID register; fetch_fault sticky fault.
// Optional: FETCH_MISALIGN_CHK_EN halts fetch on a misaligned redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_fault
);
  logic [31:0] pc_plus4_f, pc_next;
  logic        halted, misalign;
  assign pc_plus4_f = pc_f + 32'd4;
  assign imem_addr  = {2'b00, pc_f[31:2]};
`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  assign halted   = state == HALT;
  assign misalign = pc_src_e && pc_target_e[1:0] != 2'b00;
  always_ff @(posedge clk)
    if (rst) begin
      state       <= RUN;
      fetch_fault <= 1'b0;
    end else if (!halted && misalign) begin
      state       <= HALT;
      fetch_fault <= 1'b1;
    end
`else
  assign halted      = 1'b0;
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  // redirect outranks stall_f; a rejected (misaligned) redirect holds the PC
  always_comb
    pc_next = (halted || (pc_src_e ? misalign : stall_f)) ? pc_f
            : pc_src_e ? (pc_target_e & 32'hFFFF_FFFC)
            : pc_plus4_f;
  always_ff @(posedge clk)
    pc_f <= rst ? RESET_PC : pc_next;
  always_ff @(posedge clk)
    if (rst || flush_d) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= halted ? NOP_INSTR : imem_rd;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= !halted;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random stimulus against a behavioural fetch model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        clk = 0, rst = 1, stall_f = 0, stall_d = 0, flush_d = 0, pc_src_e = 0;
  logic [31:0] pc_target_e = 0;
  logic [31:0] imem_addr, imem_rd, pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fetch_fault;
  int tests = 0, fails = 0;
  logic [31:0] m_pc, m_instr, m_pcd, m_p4;
  logic        m_valid, m_fault, m_halt;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // memory contents are a fixed function of the word index
  function automatic logic [31:0] word_at(input logic [31:0] idx);
    return idx * 32'h0101_0193 ^ 32'h5A00_0001;
  endfunction
  assign imem_rd = word_at(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_f", pc_f, m_pc);
    chk("imem_addr", imem_addr, m_pc / 4);
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pcd);
    chk("pc_plus4_d", pc_plus4_d, m_p4);
    chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  task automatic step(input logic r, sf, sd, fd, src, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = src; pc_target_e = tgt;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0; m_fault = 0; m_halt = 0;
    end else begin
      if (fd) begin
        m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0;
      end else if (!sd) begin
        m_instr = m_halt ? NOP : word_at(m_pc / 4);
        m_pcd = m_pc; m_p4 = m_pc + 4; m_valid = !m_halt;
      end
      if (!m_halt) begin
        if (src) begin
          if (CHK && tgt % 4 != 0) begin m_fault = 1; m_halt = 1; end
          else m_pc = tgt - tgt % 4;
        end else if (!sf) m_pc = m_pc + 4;
      end
    end
    #1 check_all();
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h40);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 32'h20);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h80);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h22);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h44);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic r, sf, sd, fd, src;
      logic [31:0] tgt;
      r = $urandom_range(0, 39) == 0;
      src = $urandom_range(0, 5) == 0;
      tgt = ($urandom & 32'h0000_03FC) | (($urandom_range(0, 7) == 0) ? ($urandom & 32'h3) : 32'h0);
      fd = src | ($urandom_range(0, 9) == 0);
      sf = $urandom_range(0, 4) == 0;
      sd = $urandom_range(0, 1) == 0 ? sf : ($urandom_range(0, 5) == 0);
      step(r, sf, sd, fd, src, tgt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
